// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-port data RAM arbiter.
// Default bus widths and port indices.
package ram_arb_pkg;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int PORT_CPU = 0;
    localparam int PORT_DBG = 1;

endpackage

// File: rtl/ram_arbiter_if.sv
// One requester-side RAM access channel (request/ack).
// master: req/we/addr/wdata out, ack/rdata in; slave: the reverse.
interface ram_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
);

    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way combinational picker: round-robin or fixed priority.
// elig/last_grant/fixed_prio in; gnt_valid/gnt_idx out.
module rr_arb2 (
    input  logic [1:0] elig,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    always_comb begin
        gnt_valid = |elig;
        gnt_idx   = 1'b0;
        if (elig == 2'b11) begin
            // Contention: port 0 wins under fixed priority,
            // otherwise the port that was not granted last.
            gnt_idx = fixed_prio ? 1'b0 : ~last_grant;
        end else begin
            gnt_idx = elig[1];
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-port sync-write/async-read RAM between two requesters.
// Ports: clk, rst, p0/p1 (slave channels), ram_addr/ram_din/ram_we out, ram_dout in.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W     = ram_arb_pkg::ADDR_W,
    parameter int DATA_W     = ram_arb_pkg::DATA_W,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    ram_arbiter_if.slave      p0,
    ram_arbiter_if.slave      p1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    logic [1:0]        ack_q, ack_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              last_q, last_d;

    logic [1:0] elig;
    logic       gnt_valid;
    logic       gnt_idx;

    // A port in its ack cycle is not eligible, which caps each
    // port at one access per two cycles and leaves the slot free
    // for the other port.
    assign elig = {p1.req & ~ack_q[1], p0.req & ~ack_q[0]}
                & {2{~rst}};

    rr_arb2 u_pick (
        .elig       (elig),
        .last_grant (last_q),
        .fixed_prio (FIXED_PRIO != 0),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    always_comb begin
        ram_addr = '0;
        ram_din  = '0;
        ram_we   = 1'b0;
        ack_d    = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        last_d   = last_q;
        if (gnt_valid) begin
            last_d = gnt_idx;
            if (gnt_idx) begin
                ram_addr = p1.addr;
                ram_din  = p1.wdata;
                ram_we   = p1.we;
                ack_d[1] = 1'b1;
                rdata1_d = ram_dout;
            end else begin
                ram_addr = p0.addr;
                ram_din  = p0.wdata;
                ram_we   = p0.we;
                ack_d[0] = 1'b1;
                rdata0_d = ram_dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
            last_q   <= 1'b1;
        end else begin
            ack_q    <= ack_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            last_q   <= last_d;
        end
    end

    assign p0.ack   = ack_q[0];
    assign p0.rdata = rdata0_q;
    assign p1.ack   = ack_q[1];
    assign p1.rdata = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a round-robin and a fixed-priority instance
// driven identically, each with its own RAM, checked against a model.
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;

    always #5 clk = ~clk;

    // [dut][port]
    logic [1:0][1:0]       req_s, we_s, ack_s;
    logic [1:0][1:0][9:0]  addr_s;
    logic [1:0][1:0][31:0] wdata_s, rdata_s;
    logic [1:0]            ram_we_s;
    logic [1:0][9:0]       ram_addr_s;
    logic [1:0][31:0]      ram_din_s, ram_dout_s;

    logic [31:0] mem [2][1024];

    int total = 0;
    int bad   = 0;

    // model state
    int          m_last [2];
    bit          m_ack  [2][2];
    logic [31:0] m_rd   [2][2];
    logic [31:0] smem   [2][1024];

    ram_arbiter_if if00 ();
    ram_arbiter_if if01 ();
    ram_arbiter_if if10 ();
    ram_arbiter_if if11 ();

    assign if00.req = req_s[0][0];  assign if00.we = we_s[0][0];
    assign if00.addr = addr_s[0][0]; assign if00.wdata = wdata_s[0][0];
    assign ack_s[0][0] = if00.ack;   assign rdata_s[0][0] = if00.rdata;
    assign if01.req = req_s[0][1];  assign if01.we = we_s[0][1];
    assign if01.addr = addr_s[0][1]; assign if01.wdata = wdata_s[0][1];
    assign ack_s[0][1] = if01.ack;   assign rdata_s[0][1] = if01.rdata;
    assign if10.req = req_s[1][0];  assign if10.we = we_s[1][0];
    assign if10.addr = addr_s[1][0]; assign if10.wdata = wdata_s[1][0];
    assign ack_s[1][0] = if10.ack;   assign rdata_s[1][0] = if10.rdata;
    assign if11.req = req_s[1][1];  assign if11.we = we_s[1][1];
    assign if11.addr = addr_s[1][1]; assign if11.wdata = wdata_s[1][1];
    assign ack_s[1][1] = if11.ack;   assign rdata_s[1][1] = if11.rdata;

    ram_arbiter #(.FIXED_PRIO(0)) u_rr (
        .clk      (clk),
        .rst      (rst),
        .p0       (if00),
        .p1       (if01),
        .ram_addr (ram_addr_s[0]),
        .ram_din  (ram_din_s[0]),
        .ram_we   (ram_we_s[0]),
        .ram_dout (ram_dout_s[0])
    );

    ram_arbiter #(.FIXED_PRIO(1)) u_fx (
        .clk      (clk),
        .rst      (rst),
        .p0       (if10),
        .p1       (if11),
        .ram_addr (ram_addr_s[1]),
        .ram_din  (ram_din_s[1]),
        .ram_we   (ram_we_s[1]),
        .ram_dout (ram_dout_s[1])
    );

    function automatic logic [31:0] pre(input int a);
        case (a)
            1:       return 32'h11;
            2:       return 32'h22;
            9:       return 32'h99;
            default: return 32'h0;
        endcase
    endfunction

    // RAMs: sync write, async read
    always @(posedge clk) begin
        if (mem_init) begin
            for (int d = 0; d < 2; d++)
                for (int a = 0; a < 1024; a++)
                    mem[d][a] <= pre(a);
        end else begin
            for (int d = 0; d < 2; d++)
                if (ram_we_s[d]) mem[d][ram_addr_s[d]] <= ram_din_s[d];
        end
    end

    assign ram_dout_s[0] = mem[0][ram_addr_s[0]];
    assign ram_dout_s[1] = mem[1][ram_addr_s[1]];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Check one cycle of one DUT against the model, then advance the
    // model across the coming posedge.
    task automatic model_step(input int d);
        bit e0, e1;
        int g;
        logic [9:0]  ga;
        logic [31:0] gd;
        bit          gw;
        e0 = req_s[d][0] && !m_ack[d][0] && !rst;
        e1 = req_s[d][1] && !m_ack[d][1] && !rst;
        if (e0 && e1) g = (d == 1) ? 0 : 1 - m_last[d];
        else if (e0)  g = 0;
        else if (e1)  g = 1;
        else          g = -1;
        ga = (g >= 0) ? addr_s[d][g]  : 10'd0;
        gd = (g >= 0) ? wdata_s[d][g] : 32'd0;
        gw = (g >= 0) ? bit'(we_s[d][g]) : 1'b0;
        chk($sformatf("d%0d ram_we", d),   {31'd0, ram_we_s[d]}, {31'd0, gw});
        chk($sformatf("d%0d ram_addr", d), {22'd0, ram_addr_s[d]}, {22'd0, ga});
        chk($sformatf("d%0d ram_din", d),  ram_din_s[d], gd);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("d%0d ack%0d", d, p),
                {31'd0, ack_s[d][p]}, {31'd0, m_ack[d][p]});
            chk($sformatf("d%0d rdata%0d", d, p), rdata_s[d][p], m_rd[d][p]);
        end
        if (rst) begin
            m_ack[d][0] = 0; m_ack[d][1] = 0;
            m_rd[d][0] = 0;  m_rd[d][1] = 0;
            m_last[d] = 1;
        end else begin
            m_ack[d][0] = 0; m_ack[d][1] = 0;
            if (g >= 0) begin
                m_ack[d][g] = 1;
                m_rd[d][g] = smem[d][ga];
                if (gw) smem[d][ga] = gd;
                m_last[d] = g;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic r, input logic w,
                            input logic [9:0] a, input logic [31:0] wd);
        for (int d = 0; d < 2; d++) begin
            req_s[d][p] = r; we_s[d][p] = w;
            addr_s[d][p] = a; wdata_s[d][p] = wd;
        end
    endtask

    task automatic ack_is(input string n, input int d, input int p,
                          input logic v);
        chk($sformatf("%s d%0d ack%0d", n, d, p), {31'd0, ack_s[d][p]}, {31'd0, v});
    endtask

    task automatic rd_is(input string n, input int d, input int p,
                         input logic [31:0] v);
        chk($sformatf("%s d%0d rdata%0d", n, d, p), rdata_s[d][p], v);
    endtask

    // single uncontended access on port p, both DUTs
    task automatic access(input string n, input int p, input logic w,
                          input logic [9:0] a, input logic [31:0] wd,
                          input bit chk_rd, input logic [31:0] exp);
        set_port(p, 1'b1, w, a, wd);
        tick();
        for (int d = 0; d < 2; d++) begin
            ack_is(n, d, p, 1'b1);
            if (chk_rd) rd_is(n, d, p, exp);
        end
        set_port(p, 1'b0, w, a, wd);
        tick();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_last[d] = 1;
            for (int p = 0; p < 2; p++) begin
                m_ack[d][p] = 0; m_rd[d][p] = 0;
            end
            for (int a = 0; a < 1024; a++) smem[d][a] = pre(a);
        end
        rst = 1'b1;
        mem_init = 1'b1;
        set_port(0, 1'b1, 1'b0, 10'd0, 32'd0);
        set_port(1, 1'b1, 1'b0, 10'd0, 32'd0);
        @(posedge clk);
        #1;
        mem_init = 1'b0;

        // reset held with both requesting
        for (int k = 0; k < 2; k++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                ack_is("rst", d, 0, 1'b0);
                ack_is("rst", d, 1, 1'b0);
                rd_is("rst", d, 0, 32'h0);
                rd_is("rst", d, 1, 32'h0);
                chk($sformatf("rst d%0d ram_we", d), {31'd0, ram_we_s[d]}, 32'd0);
            end
        end
        rst = 1'b0;
        set_port(0, 1'b0, 1'b0, 10'd0, 32'd0);
        set_port(1, 1'b0, 1'b0, 10'd0, 32'd0);
        tick();

        // write then read on port 0
        access("wr5", 0, 1'b1, 10'd5, 32'hDEADBEEF, 1'b0, 32'h0);
        for (int d = 0; d < 2; d++)
            chk($sformatf("mem5 d%0d", d), mem[d][5], 32'hDEADBEEF);
        access("rd5", 0, 1'b0, 10'd5, 32'h0, 1'b1, 32'hDEADBEEF);

        // port 1 goes last so port 0 wins the next tie
        access("rd2p1", 1, 1'b0, 10'd2, 32'h0, 1'b1, 32'h22);

        // continuous contention: 0,1,0,1 on both instances
        set_port(0, 1'b1, 1'b0, 10'd1, 32'h0);
        set_port(1, 1'b1, 1'b0, 10'd2, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                ack_is("rr", d, 0, (k % 2) == 0);
                ack_is("rr", d, 1, (k % 2) == 1);
                if (k % 2 == 0) rd_is("rr", d, 0, 32'h11);
                else            rd_is("rr", d, 1, 32'h22);
            end
        end
        set_port(0, 1'b0, 1'b0, 10'd0, 32'h0);
        set_port(1, 1'b0, 1'b0, 10'd0, 32'h0);
        tick();

        // port 0 goes last, then both rise together
        access("rd1p0", 0, 1'b0, 10'd1, 32'h0, 1'b1, 32'h11);
        set_port(0, 1'b1, 1'b0, 10'd2, 32'h0);
        set_port(1, 1'b1, 1'b0, 10'd1, 32'h0);
        tick();
        ack_is("tie1", 0, 1, 1'b1); ack_is("tie1", 0, 0, 1'b0);
        rd_is("tie1", 0, 1, 32'h11);
        ack_is("tie1", 1, 0, 1'b1); ack_is("tie1", 1, 1, 1'b0);
        rd_is("tie1", 1, 0, 32'h22);
        tick();
        ack_is("tie2", 0, 0, 1'b1); rd_is("tie2", 0, 0, 32'h22);
        ack_is("tie2", 1, 1, 1'b1); rd_is("tie2", 1, 1, 32'h11);
        set_port(0, 1'b0, 1'b0, 10'd0, 32'h0);
        set_port(1, 1'b0, 1'b0, 10'd0, 32'h0);
        tick();

        // cross-port: port 0 reads in port 1's write-ack cycle
        set_port(1, 1'b1, 1'b1, 10'd7, 32'hA5A5A5A5);
        tick();
        for (int d = 0; d < 2; d++) ack_is("x7w", d, 1, 1'b1);
        set_port(1, 1'b0, 1'b0, 10'd0, 32'h0);
        set_port(0, 1'b1, 1'b0, 10'd7, 32'h0);
        tick();
        for (int d = 0; d < 2; d++) begin
            ack_is("x7r", d, 0, 1'b1);
            rd_is("x7r", d, 0, 32'hA5A5A5A5);
        end
        set_port(0, 1'b0, 1'b0, 10'd0, 32'h0);
        tick();

        // reset during the grant cycle of a write
        set_port(0, 1'b1, 1'b1, 10'd9, 32'hBAD00009);
        rst = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            ack_is("rstw", d, 0, 1'b0);
            chk($sformatf("rstw d%0d mem9", d), mem[d][9], 32'h99);
        end
        rst = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) ack_is("reiss", d, 0, 1'b1);
        set_port(0, 1'b0, 1'b0, 10'd0, 32'h0);
        tick();
        for (int d = 0; d < 2; d++)
            chk($sformatf("reiss d%0d mem9", d), mem[d][9], 32'hBAD00009);
        access("rd9", 0, 1'b0, 10'd9, 32'h0, 1'b1, 32'hBAD00009);

        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
